inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 159 +++++++++++++++
 tb/tb_inta_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// INTA acknowledge sequencer: two-pulse vector cycle with optional cascade.
// Cascade ownership and CAS addressing are enabled by defining CASCADE_EN.
module inta_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] highest_priority_int,
  input  logic [4:0] V_A,
  input  logic       AEOI,
  input  logic       SNGL,
  input  logic       SP,
  input  logic [7:0] slave_map,
  input  logic [2:0] slave_id,
  input  logic [2:0] cas_in,
  input  logic       init_clear,
  output logic       INT,
  output logic       S_P,
  output logic       eoi_pulse,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       freeze
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    GAP,
    ACK2
  } state_e;

  state_e     state_q;
  logic       prev_q;
  logic       spur_q;
  logic [2:0] lvl_q;
  logic       int_q;
  logic       sp_q;
  logic       eoi_q;
  logic       oe_q;
  logic       cas_oe_q;
  logic       frz_q;
  logic [7:0] dout_q;
  logic [2:0] cas_q;

  logic       fall;
  logic       rise;
  logic [2:0] lvl_d;
  logic       casc_d;
  logic       owner;

  assign fall  = prev_q & ~inta_n;
  assign rise  = ~prev_q & inta_n;
  assign lvl_d = int_req ? highest_priority_int : 3'd7;

`ifdef CASCADE_EN
  assign casc_d = SP & ~SNGL & slave_map[lvl_d];
  assign owner  = SNGL
                | (SP & ~slave_map[lvl_q])
                | (~SP & (cas_in == slave_id));
`else
  logic unused_cfg;
  assign unused_cfg = ^{SNGL, SP, slave_map, slave_id, cas_in};
  assign casc_d     = 1'b0;
  assign owner      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= 1'b1;
      spur_q   <= 1'b0;
      lvl_q    <= 3'd0;
      int_q    <= 1'b0;
      sp_q     <= 1'b0;
      eoi_q    <= 1'b0;
      oe_q     <= 1'b0;
      cas_oe_q <= 1'b0;
      frz_q    <= 1'b0;
      dout_q   <= 8'd0;
      cas_q    <= 3'd0;
    end else begin
      prev_q <= inta_n;
      sp_q   <= 1'b0;
      eoi_q  <= 1'b0;
      if (init_clear) begin
        state_q  <= IDLE;
        spur_q   <= 1'b0;
        int_q    <= 1'b0;
        oe_q     <= 1'b0;
        cas_oe_q <= 1'b0;
        frz_q    <= 1'b0;
        dout_q   <= 8'd0;
        cas_q    <= 3'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (int_req) begin
              state_q <= REQ;
              int_q   <= 1'b1;
            end
          end
          REQ: begin
            // a request that vanished at the fall becomes a spurious level 7
            if (fall) begin
              state_q <= ACK1;
              lvl_q   <= lvl_d;
              spur_q  <= ~int_req;
              sp_q    <= int_req;
              frz_q   <= 1'b1;
              if (casc_d) begin
                cas_oe_q <= 1'b1;
                cas_q    <= lvl_d;
              end
            end else if (!int_req) begin
              state_q <= IDLE;
              int_q   <= 1'b0;
            end
          end
          ACK1: begin
            if (rise) state_q <= GAP;
          end
          GAP: begin
            if (fall) begin
              state_q <= ACK2;
              dout_q  <= {V_A, lvl_q};
              oe_q    <= owner;
            end
          end
          ACK2: begin
            if (rise) begin
              state_q  <= IDLE;
              eoi_q    <= AEOI & ~spur_q;
              int_q    <= 1'b0;
              oe_q     <= 1'b0;
              cas_oe_q <= 1'b0;
              frz_q    <= 1'b0;
              dout_q   <= 8'd0;
              cas_q    <= 3'd0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign INT       = int_q;
  assign S_P       = sp_q;
  assign eoi_pulse = eoi_q;
  assign data_out  = dout_q;
  assign data_oe   = oe_q;
  assign cas_out   = cas_q;
  assign cas_oe    = cas_oe_q;
  assign freeze    = frz_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: one expected record per INT episode,
// compared by a monitor when INT falls.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       inta_n;
  logic       int_req;
  logic [2:0] highest_priority_int;
  logic [4:0] V_A;
  logic       AEOI;
  logic       SNGL;
  logic       SP;
  logic [7:0] slave_map;
  logic [2:0] slave_id;
  logic [2:0] cas_in;
  logic       init_clear;
  logic       INT;
  logic       S_P;
  logic       eoi_pulse;
  logic [7:0] data_out;
  logic       data_oe;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic       freeze;

  inta_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .inta_n               (inta_n),
    .int_req              (int_req),
    .highest_priority_int (highest_priority_int),
    .V_A                  (V_A),
    .AEOI                 (AEOI),
    .SNGL                 (SNGL),
    .SP                   (SP),
    .slave_map            (slave_map),
    .slave_id             (slave_id),
    .cas_in               (cas_in),
    .init_clear           (init_clear),
    .INT                  (INT),
    .S_P                  (S_P),
    .eoi_pulse            (eoi_pulse),
    .data_out             (data_out),
    .data_oe              (data_oe),
    .cas_out              (cas_out),
    .cas_oe               (cas_oe),
    .freeze               (freeze)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sp;
    int         eoi;
    int         oe;
    logic [7:0] dout;
    logic       caso;
    logic [2:0] cas;
    logic       frz;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int sp, input int eoi, input int oe,
                              input logic [7:0] dout, input logic caso,
                              input logic [2:0] cas, input logic frz);
    exp_t e;
    e.sp = sp; e.eoi = eoi; e.oe = oe; e.dout = dout;
    e.caso = caso; e.cas = cas; e.frz = frz;
    return e;
  endfunction

  // monitor: accumulate one INT episode, compare when INT falls
  int         a_sp = 0, a_eoi = 0, a_oe = 0;
  logic [7:0] a_dout = 0;
  logic       a_caso = 0;
  logic [2:0] a_cas = 0;
  logic       a_frz = 0;
  logic       int_d = 0;

  always @(negedge clk) begin
    if (S_P === 1'b1) a_sp++;
    if (eoi_pulse === 1'b1) a_eoi++;
    if (data_oe === 1'b1) a_oe++;
    if (data_out !== 8'd0) a_dout = data_out;
    if (cas_oe === 1'b1) begin
      a_caso = 1'b1;
      a_cas  = cas_out;
    end
    if (freeze === 1'b1) a_frz = 1'b1;
    if (int_d === 1'b1 && INT === 1'b0) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_episode", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("sp_count", a_sp, e.sp);
        cmp("eoi_count", a_eoi, e.eoi);
        cmp("oe_cycles", a_oe, e.oe);
        cmp("data_out", a_dout, e.dout);
        cmp("cas_oe", a_caso, e.caso);
        cmp("cas_out", a_cas, e.cas);
        cmp("freeze", a_frz, e.frz);
      end
      a_sp = 0; a_eoi = 0; a_oe = 0; a_dout = 0;
      a_caso = 0; a_cas = 0; a_frz = 0;
    end
    int_d = INT;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abort: 0 = none, 1 = rst in GAP, 2 = init_clear in GAP
  task automatic txn(input logic [4:0] va, input logic [2:0] lvl,
                     input logic aeoi, input bit spur, input int abort,
                     input exp_t e);
    exp_q.push_back(e);
    V_A = va;
    highest_priority_int = lvl;
    AEOI = aeoi;
    int_req = 1'b1;
    step(2);
    inta_n = 1'b0;
    if (spur) int_req = 1'b0;
    step(1);
    int_req = 1'b0;
    step(1);
    inta_n = 1'b1;
    step(2);
    if (abort != 0) begin
      if (abort == 1) rst = 1'b1;
      else init_clear = 1'b1;
      step(1);
      cmp("abort_int", INT, 0);
      cmp("abort_oe", data_oe, 0);
      rst = 1'b0;
      init_clear = 1'b0;
      step(3);
      cmp("abort_quiet", {S_P, eoi_pulse, INT}, 0);
      return;
    end
    inta_n = 1'b0;
    step(3);
    inta_n = 1'b1;
    step(3);
  endtask

  initial begin
    rst = 1'b1;
    inta_n = 1'b1;
    int_req = 1'b0;
    highest_priority_int = 3'd0;
    V_A = 5'd0;
    AEOI = 1'b0;
    SNGL = 1'b1;
    SP = 1'b1;
    slave_map = 8'h00;
    slave_id = 3'd0;
    cas_in = 3'd0;
    init_clear = 1'b0;
    step(3);
    cmp("rst_INT", INT, 0);
    cmp("rst_pulses", {S_P, eoi_pulse}, 0);
    cmp("rst_oes", {data_oe, cas_oe, freeze}, 0);
    cmp("rst_data_out", data_out, 0);
    cmp("rst_cas_out", cas_out, 0);
    rst = 1'b0;
    step(2);

    // single PIC, level 5, vector base 08
    txn(5'h08, 3'd5, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h45, 0, 3'd0, 1));
    // automatic EOI on, then off
    txn(5'h08, 3'd3, 1'b1, 1'b0, 0, mk(1, 1, 3, 8'h43, 0, 3'd0, 1));
    txn(5'h08, 3'd3, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h43, 0, 3'd0, 1));
    // spurious: request gone at the first fall
    txn(5'h10, 3'd2, 1'b1, 1'b1, 0, mk(0, 0, 3, 8'h87, 0, 3'd0, 1));

    // request withdrawn while waiting for INTA
    exp_q.push_back(mk(0, 0, 0, 8'h00, 0, 3'd0, 0));
    int_req = 1'b1;
    highest_priority_int = 3'd6;
    step(2);
    int_req = 1'b0;
    step(3);

    // cascade: master with slave on IR4
    SNGL = 1'b0;
    SP = 1'b1;
    slave_map = 8'h10;
`ifdef CASCADE_EN
    txn(5'h08, 3'd4, 1'b0, 1'b0, 0, mk(1, 0, 0, 8'h44, 1, 3'd4, 1));
`else
    txn(5'h08, 3'd4, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h44, 0, 3'd0, 1));
`endif
    // master, own level (no slave on IR1)
    txn(5'h08, 3'd1, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h41, 0, 3'd0, 1));
    // slave addressed by matching cas_in
    SP = 1'b0;
    slave_id = 3'd4;
    cas_in = 3'd4;
    txn(5'h0C, 3'd2, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h62, 0, 3'd0, 1));
    // slave not addressed
    cas_in = 3'd3;
`ifdef CASCADE_EN
    txn(5'h0C, 3'd2, 1'b0, 1'b0, 0, mk(1, 0, 0, 8'h62, 0, 3'd0, 1));
`else
    txn(5'h0C, 3'd2, 1'b0, 1'b0, 0, mk(1, 0, 3, 8'h62, 0, 3'd0, 1));
`endif
    SNGL = 1'b1;
    SP = 1'b1;
    slave_map = 8'h00;

    // aborts in GAP, AEOI on so a stray EOI would be counted
    txn(5'h08, 3'd1, 1'b1, 1'b0, 1, mk(1, 0, 0, 8'h00, 0, 3'd0, 1));
    txn(5'h08, 3'd1, 1'b1, 1'b0, 2, mk(1, 0, 0, 8'h00, 0, 3'd0, 1));

    // normal cycle still works after the aborts
    txn(5'h1F, 3'd0, 1'b1, 1'b0, 0, mk(1, 1, 3, 8'hF8, 0, 3'd0, 1));

    step(4);
    cmp("episodes_left", exp_q.size(), 0);
    cmp("stray_pulses", a_sp + a_eoi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
